ram_refresh_timer: RTL and testbench

- Upstream refresh-request generator for the DRAM controller; drives its RefReqIn and RefUrgIn inputs.
- A free-running period counter opens one refresh slot per period.
- Within each slot it raises a soft request first, then escalates to urgent, then drops both. The controller therefore sees a low gap and re-arms its one-refresh-per-slot latch.
- Sits beside the bus/clock logic in the CPLD and is clocked from the same CLK.

---
 rtl/ram_refresh_timer.sv | 130 +++++++++++++
 tb/tb_ram_refresh_timer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_refresh_timer.sv
// Refresh-request timer for the DRAM controller.
// A free-running slot counter opens one refresh slot every PERIOD clocks.
// Each slot raises a soft request, escalates it to urgent at URG_AT, then
// drops both for the rest of the slot. The controller needs that low gap
// to re-arm its one-refresh-per-slot latch.
module ram_refresh_timer #(
    parameter int unsigned PERIOD  = 384,
    parameter int unsigned URG_AT  = 192,
    parameter int unsigned URG_LEN = 16,
    parameter int unsigned CW      = 9
) (
    input  logic       CLK,
    input  logic       nRST,
    input  logic       EN,
    input  logic       RefSync,
    output logic       RefReqOut,
    output logic       RefUrgOut,
    output logic [1:0] RefPhase,
    output logic       SlotTick
);

    // Parameter sanity: the slot must leave at least two low cycles, and
    // the counter must be able to hold PERIOD-1.
    if (PERIOD < URG_AT + URG_LEN + 2) begin : gBadPeriod
        $error("ram_refresh_timer: PERIOD must be >= URG_AT+URG_LEN+2");
    end
    if ((64'd1 << CW) < 64'(PERIOD)) begin : gBadWidth
        $error("ram_refresh_timer: CW too narrow for PERIOD");
    end
    if (URG_AT < 1 || URG_LEN < 1) begin : gBadUrg
        $error("ram_refresh_timer: URG_AT and URG_LEN must be >= 1");
    end

    // Encoding doubles as the RefPhase debug code.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        URG  = 2'd2,
        GAP  = 2'd3
    } phaseT;

    localparam logic [CW-1:0] LAST_REQ  = CW'(URG_AT - 1);
    localparam logic [CW-1:0] LAST_URG  = CW'(URG_AT + URG_LEN - 1);
    localparam logic [CW-1:0] LAST_SLOT = CW'(PERIOD - 1);

    phaseT         state;
    logic [CW-1:0] slotCount;
    logic          forceGap;   // current cycle is the forced low cycle after a sync
    logic          syncNeedsGap;

    // A sync from a slot with requests high must first show one low cycle.
    // A sync landing on the natural wrap is treated the same way so the
    // controller still gets a clean gap and no SlotTick is emitted.
    assign syncNeedsGap = RefSync && !forceGap &&
                          ((state == REQ) || (state == URG) ||
                           ((state == GAP) && (slotCount == LAST_SLOT)));

    assign RefPhase = state;

    // Slot counter, phase FSM and registered request outputs.
    // SlotTick is raised on the wrap edge, so it is high in the first
    // cycle of the new slot; this lets a coincident RefSync suppress it.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            slotCount <= '0;
            forceGap  <= 1'b0;
            RefReqOut <= 1'b0;
            RefUrgOut <= 1'b0;
            SlotTick  <= 1'b0;
        end else if (!EN) begin
            state     <= IDLE;
            slotCount <= '0;
            forceGap  <= 1'b0;
            RefReqOut <= 1'b0;
            RefUrgOut <= 1'b0;
            SlotTick  <= 1'b0;
        end else if (syncNeedsGap) begin
            state     <= GAP;
            slotCount <= '0;
            forceGap  <= 1'b1;
            RefReqOut <= 1'b0;
            RefUrgOut <= 1'b0;
            SlotTick  <= 1'b0;
        end else if (RefSync || forceGap || (state == IDLE)) begin
            state     <= REQ;
            slotCount <= '0;
            forceGap  <= 1'b0;
            RefReqOut <= 1'b1;
            RefUrgOut <= 1'b0;
            SlotTick  <= 1'b0;
        end else begin
            SlotTick <= 1'b0;
            case (state)
                REQ: begin
                    slotCount <= slotCount + CW'(1);
                    if (slotCount == LAST_REQ) begin
                        state     <= URG;
                        RefUrgOut <= 1'b1;
                    end
                end
                URG: begin
                    slotCount <= slotCount + CW'(1);
                    if (slotCount == LAST_URG) begin
                        state     <= GAP;
                        RefReqOut <= 1'b0;
                        RefUrgOut <= 1'b0;
                    end
                end
                GAP: begin
                    if (slotCount == LAST_SLOT) begin
                        state     <= REQ;
                        slotCount <= '0;
                        RefReqOut <= 1'b1;
                        SlotTick  <= 1'b1;
                    end else begin
                        slotCount <= slotCount + CW'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    slotCount <= '0;
                    RefReqOut <= 1'b0;
                    RefUrgOut <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_refresh_timer.sv
// Directed and randomised checks for ram_refresh_timer with default timing.
module tb_ram_refresh_timer;

    localparam int PERIOD  = 384;
    localparam int URG_AT  = 192;
    localparam int URG_LEN = 16;
    localparam int GAP_LEN = PERIOD - URG_AT - URG_LEN;

    logic       CLK = 1'b0;
    logic       nRST;
    logic       EN;
    logic       RefSync;
    logic       RefReqOut;
    logic       RefUrgOut;
    logic [1:0] RefPhase;
    logic       SlotTick;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    ram_refresh_timer #(
        .PERIOD (PERIOD),
        .URG_AT (URG_AT),
        .URG_LEN(URG_LEN),
        .CW     (9)
    ) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .EN       (EN),
        .RefSync  (RefSync),
        .RefReqOut(RefReqOut),
        .RefUrgOut(RefUrgOut),
        .RefPhase (RefPhase),
        .SlotTick (SlotTick)
    );

    // Packed view {req, urg, phase[1:0], tick}
    localparam logic [31:0] IDLE_V = 32'b00000;
    localparam logic [31:0] GAP_V  = 32'b00110;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] obsVec();
        return {27'b0, RefReqOut, RefUrgOut, RefPhase, SlotTick};
    endfunction

    // Expected outputs at slot offset c of an undisturbed slot.
    function automatic logic [31:0] slotExp(input int c, input bit tick);
        if (c < URG_AT)                return {27'b0, 4'b1001, tick};
        else if (c < URG_AT + URG_LEN) return {27'b0, 4'b1110, tick};
        else                           return {27'b0, 4'b0011, tick};
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic stepN(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Reset, release with EN high; returns sampled in slot cycle 0.
    task automatic restart();
        nRST    = 1'b0;
        EN      = 1'b1;
        RefSync = 1'b0;
        repeat (2) @(posedge CLK);
        #2;
        nRST = 1'b1;
        step();
    endtask

    initial begin
        int enLowLeft;
        int lowRun;
        int lastTick;
        int r;
        bit prevReq;
        bit haveTick;
        bit distGap;
        bit distTick;

        nRST    = 1'b0;
        EN      = 1'b0;
        RefSync = 1'b0;
        #12;
        checkVal("resetState", obsVec(), IDLE_V);
        EN = 1'b1;
        step();
        checkVal("resetHeld", obsVec(), IDLE_V);

        // Two undisturbed slots from release, including the wrap ticks.
        #2;
        nRST = 1'b1;
        step();
        for (int c = 0; c <= 2 * PERIOD; c++) begin
            if (c > 0) step();
            checkVal($sformatf("slot c=%0d", c), obsVec(),
                     slotExp(c % PERIOD, (c == PERIOD) || (c == 2 * PERIOD)));
        end

        // Asynchronous reset inside URG, then a fresh slot.
        restart();
        stepN(200);
        checkVal("preRstUrg", obsVec(), slotExp(200, 1'b0));
        #2;
        nRST = 1'b0;
        #1;
        checkVal("asyncRst", obsVec(), IDLE_V);
        step();
        checkVal("rstHold", obsVec(), IDLE_V);
        #2;
        nRST = 1'b1;
        step();
        checkVal("rstFresh0", obsVec(), slotExp(0, 1'b0));
        stepN(191);
        checkVal("rstFresh191", obsVec(), slotExp(191, 1'b0));
        step();
        checkVal("rstFresh192", obsVec(), slotExp(192, 1'b0));

        // RefSync during REQ: one forced low cycle, then a new slot.
        restart();
        stepN(100);
        RefSync = 1'b1;
        step();
        RefSync = 1'b0;
        checkVal("syncGap", obsVec(), GAP_V);
        step();
        checkVal("syncReq0", obsVec(), slotExp(0, 1'b0));
        stepN(191);
        checkVal("syncReq191", obsVec(), slotExp(191, 1'b0));
        step();
        checkVal("syncUrg192", obsVec(), slotExp(192, 1'b0));

        // EN dropped in URG for 50 cycles; sync ignored while disabled.
        restart();
        stepN(195);
        checkVal("preEnUrg", obsVec(), slotExp(195, 1'b0));
        EN = 1'b0;
        step();
        checkVal("enOffIdle", obsVec(), IDLE_V);
        stepN(20);
        RefSync = 1'b1;
        step();
        RefSync = 1'b0;
        checkVal("syncIgnored", obsVec(), IDLE_V);
        stepN(28);
        checkVal("enOffStill", obsVec(), IDLE_V);
        EN = 1'b1;
        step();
        checkVal("enOnReq0", obsVec(), slotExp(0, 1'b0));
        stepN(191);
        checkVal("enOn191", obsVec(), slotExp(191, 1'b0));
        step();
        checkVal("enOn192", obsVec(), slotExp(192, 1'b0));

        // RefSync coinciding with the natural wrap.
        restart();
        stepN(PERIOD - 1);
        checkVal("preWrap", obsVec(), slotExp(PERIOD - 1, 1'b0));
        RefSync = 1'b1;
        step();
        RefSync = 1'b0;
        checkVal("wrapSyncGap", obsVec(), GAP_V);
        step();
        checkVal("wrapSyncReq", obsVec(), slotExp(0, 1'b0));
        stepN(192);
        checkVal("wrapSyncUrg", obsVec(), slotExp(192, 1'b0));

        // Random EN/RefSync: invariants, gap length and tick spacing.
        restart();
        enLowLeft = 0;
        lowRun    = 0;
        lastTick  = 0;
        prevReq   = 1'b1;
        haveTick  = 1'b0;
        distGap   = 1'b0;
        distTick  = 1'b0;
        for (int i = 1; i <= 30000; i++) begin
            step();
            checkVal("urgImpliesReq", {31'b0, RefUrgOut & ~RefReqOut}, 32'd0);
            if (!RefReqOut) lowRun++;
            if (RefReqOut && !prevReq) begin
                if (!distGap) checkVal("gapLen", 32'(lowRun), 32'(GAP_LEN));
                distGap = 1'b0;
            end
            if (RefReqOut) lowRun = 0;
            prevReq = RefReqOut;
            if (SlotTick) begin
                if (haveTick && !distTick) checkVal("tickSpacing", 32'(i - lastTick), 32'(PERIOD));
                haveTick = 1'b1;
                lastTick = i;
                distTick = 1'b0;
            end
            RefSync = 1'b0;
            if (enLowLeft > 0) begin
                EN = 1'b0;
                enLowLeft--;
            end else begin
                EN = 1'b1;
                r  = int'($urandom_range(0, 3999));
                if (r < 2) begin
                    EN        = 1'b0;
                    enLowLeft = int'($urandom_range(1, 9));
                    distGap   = 1'b1;
                    distTick  = 1'b1;
                end else if (r < 4) begin
                    RefSync  = 1'b1;
                    distGap  = 1'b1;
                    distTick = 1'b1;
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
